// File: rtl/crc8_frame_appender_if.sv
// Byte-stream bundle around the CRC8 frame appender: source side, link side and crc8 core side.
// The slave modport is the appender's view; the master modport is the surrounding system's view.
interface crc8_frame_appender_if;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_last_i;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_last_o;
  logic       m_ready_i;
  logic [7:0] crc_data_o;
  logic       crc_valid_o;
  logic       crc_rst_o;
  logic [7:0] crc_i;
  logic       frame_err_o;

  modport slave (
    input  s_data_i, s_valid_i, s_last_i, m_ready_i, crc_i,
    output s_ready_o, m_data_o, m_valid_o, m_last_o,
           crc_data_o, crc_valid_o, crc_rst_o, frame_err_o
  );

  modport master (
    output s_data_i, s_valid_i, s_last_i, m_ready_i, crc_i,
    input  s_ready_o, m_data_o, m_valid_o, m_last_o,
           crc_data_o, crc_valid_o, crc_rst_o, frame_err_o
  );
endinterface

// File: rtl/crc8_frame_appender.sv
// Forwards payload bytes to the link and appends the crc8 core's result as a final byte.
// Optional macro CRC8_APPEND_INVERT_EN: appended byte is the core's CRC inverted.
module crc8_frame_appender #(
  parameter int MAX_FRAME_LEN = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  crc8_frame_appender_if.slave bus
);
  // state  | meaning
  // DATA   | forward payload bytes, feed the crc8 core
  // WAIT   | one bubble so the core absorbs the last payload byte
  // APPEND | emit the core's CRC as the last byte, then clear the core
  typedef enum logic [1:0] {DATA, WAIT, APPEND} state_t;

  localparam int LEN_W = $clog2(MAX_FRAME_LEN + 1);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_next;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_last;
  logic             frame_err;
  logic [7:0]       crc_byte;
  logic             out_free;
  logic             ready;
  logic             take;
  logic             emit_crc;
  logic             len_full;

`ifdef CRC8_APPEND_INVERT_EN
  assign crc_byte = bus.crc_i ^ 8'hFF;
`else
  assign crc_byte = bus.crc_i;
`endif

  assign out_free = !m_valid | bus.m_ready_i;
  // Gated by rst_ni so a clear and a data strobe never reach the core together.
  assign ready    = rst_ni & (state == DATA) & out_free;
  assign take     = bus.s_valid_i & ready;
  assign emit_crc = rst_ni & (state == APPEND) & out_free;
  assign len_next = len + LEN_W'(1);
  assign len_full = (len_next == LEN_W'(MAX_FRAME_LEN));

  assign bus.s_ready_o   = ready;
  assign bus.m_data_o    = m_data;
  assign bus.m_valid_o   = m_valid;
  assign bus.m_last_o    = m_last;
  assign bus.crc_data_o  = bus.s_data_i;
  assign bus.crc_valid_o = take;
  assign bus.crc_rst_o   = !rst_ni | emit_crc;
  assign bus.frame_err_o = frame_err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= DATA;
      len       <= '0;
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (out_free) m_valid <= 1'b0;
      case (state)
        DATA: begin
          if (take) begin
            m_data  <= bus.s_data_i;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            len     <= len_next;
            if (bus.s_last_i || len_full) state <= WAIT;
            if (len_full && !bus.s_last_i) frame_err <= 1'b1;
          end
        end
        WAIT: state <= APPEND;
        APPEND: begin
          if (out_free) begin
            m_data  <= crc_byte;
            m_valid <= 1'b1;
            m_last  <= 1'b1;
            len     <= '0;
            state   <= DATA;
          end
        end
        default: state <= DATA;
      endcase
    end
  end
endmodule

// File: tb/tb_crc8_frame_appender.sv
// Directed bench for crc8_frame_appender: two instances (MAX_FRAME_LEN 256 and 4) with behavioural crc8 cores.
module tb_crc8_frame_appender;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic m_ready = 1'b1;
  logic tog = 1'b0;
  logic sel = 1'b0;
  logic [7:0] crc_a = 8'h00;
  logic [7:0] crc_b = 8'h00;
  int total = 0;
  int bad = 0;
  int err_a = 0;
  int err_b = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];

`ifdef CRC8_APPEND_INVERT_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  always #5 clk = ~clk;

  crc8_frame_appender_if ifa ();
  crc8_frame_appender_if ifb ();

  crc8_frame_appender #(.MAX_FRAME_LEN(256)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));
  crc8_frame_appender #(.MAX_FRAME_LEN(4))   dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));

  assign ifa.s_data_i  = s_data;
  assign ifa.s_last_i  = s_last;
  assign ifa.s_valid_i = s_valid & !sel;
  assign ifa.m_ready_i = m_ready;
  assign ifa.crc_i     = crc_a;
  assign ifb.s_data_i  = s_data;
  assign ifb.s_last_i  = s_last;
  assign ifb.s_valid_i = s_valid & sel;
  assign ifb.m_ready_i = m_ready;
  assign ifb.crc_i     = crc_b;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Behavioural crc8 cores (poly 0x07, init 0x00), result one cycle after the strobe.
  always @(posedge clk) begin
    if (ifa.crc_rst_o) crc_a <= 8'h00;
    else if (ifa.crc_valid_o) crc_a <= crc_step(crc_a, ifa.crc_data_o);
    if (ifb.crc_rst_o) crc_b <= 8'h00;
    else if (ifb.crc_valid_o) crc_b <= crc_step(crc_b, ifb.crc_data_o);
  end

  always @(posedge clk) begin
    #1;
    m_ready = tog ? !m_ready : 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  logic       pa_v = 1'b0, pa_r = 1'b0, pa_l = 1'b0;
  logic [7:0] pa_d = 8'h00;
  logic       pb_v = 1'b0, pb_r = 1'b0, pb_l = 1'b0;
  logic [7:0] pb_d = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.m_valid_o && ifa.m_ready_i) qa.push_back({ifa.m_last_o, ifa.m_data_o});
      if (ifb.m_valid_o && ifb.m_ready_i) qb.push_back({ifb.m_last_o, ifb.m_data_o});
      if (ifa.frame_err_o) err_a++;
      if (ifb.frame_err_o) err_b++;
      if (pa_v && !pa_r) chk("hold_a", {ifa.m_valid_o, ifa.m_last_o, ifa.m_data_o}, {1'b1, pa_l, pa_d});
      if (pb_v && !pb_r) chk("hold_b", {ifb.m_valid_o, ifb.m_last_o, ifb.m_data_o}, {1'b1, pb_l, pb_d});
      if (ifa.crc_valid_o) chk("crc_excl_a", int'(ifa.crc_rst_o), 0);
      if (ifb.crc_valid_o) chk("crc_excl_b", int'(ifb.crc_rst_o), 0);
    end
    pa_v = ifa.m_valid_o & rst_n; pa_r = ifa.m_ready_i; pa_l = ifa.m_last_o; pa_d = ifa.m_data_o;
    pb_v = ifb.m_valid_o & rst_n; pb_r = ifb.m_ready_i; pb_l = ifb.m_last_o; pb_d = ifb.m_data_o;
  end

  typedef struct {
    logic [7:0]  din[12];
    logic [11:0] lmask;
    int          n_in;
    logic [7:0]  dout[12];
    logic [11:0] omask;
    int          n_out;
    logic        sel;
    logic        tog;
    int          n_err;
  } vec_t;

  vec_t vecs[5];

  // Call with time just after a rising edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int w;
    s_data = d; s_last = l; s_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!(sel ? ifb.s_ready_o : ifa.s_ready_o) && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (w >= 100) chk("accept_timeout", w, 0);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic run_vec(input int k);
    int w;
    int n;
    logic [8:0] got;
    qa.delete(); qb.delete();
    err_a = 0; err_b = 0;
    sel = vecs[k].sel;
    tog = vecs[k].tog;
    @(posedge clk); #1;
    for (int i = 0; i < vecs[k].n_in; i++) send_byte(vecs[k].din[i], vecs[k].lmask[i]);
    w = 0;
    n = sel ? qb.size() : qa.size();
    while (n < vecs[k].n_out && w < 200) begin
      @(negedge clk);
      w++;
      n = sel ? qb.size() : qa.size();
    end
    repeat (6) @(negedge clk);
    n = sel ? qb.size() : qa.size();
    chk($sformatf("v%0d_count", k), n, vecs[k].n_out);
    for (int i = 0; i < vecs[k].n_out && i < n; i++) begin
      got = sel ? qb[i] : qa[i];
      chk($sformatf("v%0d_byte%0d", k, i), got,
          {vecs[k].omask[i], vecs[k].dout[i] ^ (vecs[k].omask[i] ? INV : 8'h00)});
    end
    chk($sformatf("v%0d_frame_err", k), sel ? err_b : err_a, vecs[k].n_err);
    tog = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 5; k++) begin
      vecs[k].lmask = '0; vecs[k].omask = '0; vecs[k].sel = 1'b0;
      vecs[k].tog = 1'b0; vecs[k].n_err = 0;
      for (int i = 0; i < 12; i++) begin vecs[k].din[i] = 8'h00; vecs[k].dout[i] = 8'h00; end
    end
    // "123456789" -> CRC 0xF4
    for (int i = 0; i < 9; i++) begin
      vecs[0].din[i] = 8'h31 + 8'(i);
      vecs[0].dout[i] = 8'h31 + 8'(i);
    end
    vecs[0].dout[9] = 8'hF4;
    vecs[0].lmask = 12'h100; vecs[0].n_in = 9;
    vecs[0].omask = 12'h200; vecs[0].n_out = 10;
    // single zero byte
    vecs[1].lmask = 12'h001; vecs[1].n_in = 1;
    vecs[1].omask = 12'h002; vecs[1].n_out = 2;
    // same as 0 with downstream ready toggling
    vecs[2] = vecs[0];
    vecs[2].tog = 1'b1;
    // truncation at 4 on the small instance: CRC(01..04)=E3, CRC(05,06)=53
    for (int i = 0; i < 6; i++) vecs[3].din[i] = 8'h01 + 8'(i);
    vecs[3].dout[0] = 8'h01; vecs[3].dout[1] = 8'h02; vecs[3].dout[2] = 8'h03;
    vecs[3].dout[3] = 8'h04; vecs[3].dout[4] = 8'hE3; vecs[3].dout[5] = 8'h05;
    vecs[3].dout[6] = 8'h06; vecs[3].dout[7] = 8'h53;
    vecs[3].lmask = 12'h020; vecs[3].n_in = 6;
    vecs[3].omask = 12'h090; vecs[3].n_out = 8;
    vecs[3].sel = 1'b1; vecs[3].n_err = 1;
    // back-to-back single-byte frames
    vecs[4].din[0] = 8'hAA; vecs[4].din[1] = 8'h55;
    vecs[4].dout[0] = 8'hAA; vecs[4].dout[1] = 8'h5F;
    vecs[4].dout[2] = 8'h55; vecs[4].dout[3] = 8'hAC;
    vecs[4].lmask = 12'h003; vecs[4].n_in = 2;
    vecs[4].omask = 12'h00A; vecs[4].n_out = 4;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", int'(ifa.m_valid_o), 0);
    chk("rst_m_last", int'(ifa.m_last_o), 0);
    chk("rst_m_data", int'(ifa.m_data_o), 0);
    chk("rst_frame_err", int'(ifa.frame_err_o), 0);
    chk("rst_crc_rst", int'(ifa.crc_rst_o), 1);
    chk("rst_b_m_valid", int'(ifb.m_valid_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_crc_rst", int'(ifa.crc_rst_o), 0);

    for (int k = 0; k < 5; k++) run_vec(k);

    // reset after three bytes of a frame discards it and clears the core
    sel = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_crc_rst", int'(ifa.crc_rst_o), 1);
    chk("mid_rst_ready", int'(ifa.s_ready_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_m_valid", int'(ifa.m_valid_o), 0);
    chk("mid_rst_core_clear", int'(crc_a), 0);
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
